pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage vector CPU (IF, ID, EX, MEM, WB). It consumes the decoded control fields of the instruction in ID and keeps a 3-deep scoreboard of in-flight register writes (EX, MEM, WB). From these it generates stall, bubble and flush controls for the pipeline registers and the PC. It also owns the data-memory request/acknowledge handshake for the load/store in MEM, including a timeout.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/mem_hs_fsm.sv | 97 +++++++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the 5-stage vector CPU pipeline control.
//               Opcode encoding, scoreboard entry layout, memory-handshake
//               FSM states and the scoreboard hit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [3:0] {
        RTYPE = 4'h0,
        VLD   = 4'h1,
        VSD   = 4'h2,
        VBEZ  = 4'h3,
        VBNEZ = 4'h4,
        VNOP  = 4'hF
    } opcode_e;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        logic       mem;
        logic       we;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_e;

    // True when entry e will write register r. R0 never matches.
    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
        return e.valid && e.wr && (e.rd == r) && (r != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_hs_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_hs_fsm
// Description : Data-memory request/acknowledge handshake for the MEM stage,
//               with a request timeout and a sticky error state.
// Ports       : clk, reset      - clock, async active-high reset
//               mem_op_i        - MEM stage holds a load/store
//               mem_we_i        - that access is a store
//               dmem_ack_i      - memory accepted/returned the access
//               dmem_req_o      - memory request
//               dmem_we_o       - request is a write
//               stall_all_o     - freeze the whole pipeline
//               mem_err_o       - sticky timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module mem_hs_fsm #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_op_i,
    input  logic mem_we_i,
    input  logic dmem_ack_i,
    output logic dmem_req_o,
    output logic dmem_we_o,
    output logic stall_all_o,
    output logic mem_err_o
);
    import cpu_pkg::*;

    localparam int                CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (mem_op_i && !dmem_ack_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ERR: begin
                    // Only reset leaves the error state.
                    mem_err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The ack is honoured in the same cycle, so these depend on dmem_ack_i.
    always_comb begin
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        stall_all_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_i) begin
                    dmem_req_o  = 1'b1;
                    dmem_we_o   = mem_we_i;
                    stall_all_o = !dmem_ack_i;
                end
            end
            WAIT: begin
                dmem_req_o  = 1'b1;
                dmem_we_o   = mem_we_i;
                stall_all_o = !dmem_ack_i;
            end
            ERR:     stall_all_o = 1'b1;
            default: stall_all_o = 1'b0;
        endcase
    end

    assign mem_err_o = mem_err_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline sequencing controller. Tracks in-flight register
//               writes in a 3-entry scoreboard (EX, MEM, WB), detects RAW
//               hazards and taken branches for the instruction in ID, and
//               drives the MEM-stage memory handshake.
// Ports       : clk, reset             - clock, async active-high reset
//               id_*                   - decoded fields of the ID instruction
//               dmem_ack               - memory handshake acknowledge
//               stall_front/bubble_ex  - hazard stall of PC+IF/ID, NOP into EX
//               stall_all              - freeze the whole pipeline
//               flush_if/pc_sel_branch - taken-branch redirect
//               dmem_req/dmem_we       - memory request and direction
//               mem_err                - sticky memory timeout
//               stall_cnt              - saturating stall-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT      = 64,
    parameter bit WB_WRITE_THROUGH = 1'b1,
    parameter int STALL_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic                   id_wrEn,
    input  logic                   id_memEn,
    input  logic                   id_memwrEn,
    input  logic                   id_bez,
    input  logic                   id_bnez,
    input  logic                   id_R_type,
    input  logic [4:0]             id_rD,
    input  logic [4:0]             id_rA,
    input  logic [4:0]             id_rB,
    input  logic                   id_rD_zero,
    input  logic                   dmem_ack,
    output logic                   stall_front,
    output logic                   bubble_ex,
    output logic                   stall_all,
    output logic                   flush_if,
    output logic                   pc_sel_branch,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    import cpu_pkg::*;

    localparam bit WB_CHECK = !WB_WRITE_THROUGH;

    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
    sb_entry_t sb_ex_d;

    logic                   id_store, id_load;
    logic [2:0]             rd_use;
    logic [2:0][4:0]        rd_reg;
    logic [2:0]             rd_hit;
    logic                   data_hazard;
    logic                   taken;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   wb_unused;

    assign id_store = id_memEn & id_memwrEn;
    assign id_load  = id_memEn & ~id_memwrEn;

    // Read ports: 0 = rA (R-type, store), 1 = rB (R-type), 2 = rD (store, branch)
    assign rd_use[0] = id_valid & (id_R_type | id_store);
    assign rd_use[1] = id_valid & id_R_type;
    assign rd_use[2] = id_valid & (id_store | id_bez | id_bnez);
    assign rd_reg[0] = id_rA;
    assign rd_reg[1] = id_rB;
    assign rd_reg[2] = id_rD;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
        assign rd_hit[gi] = rd_use[gi] &
                            (sb_hit(sb_ex_q,  rd_reg[gi]) |
                             sb_hit(sb_mem_q, rd_reg[gi]) |
                             (WB_CHECK & sb_hit(sb_wb_q, rd_reg[gi])));
    end

    assign data_hazard = |rd_hit;

    // Hazard stall freezes the front even under stall_all; the EX bubble and
    // branch redirect are meaningless while everything is frozen.
    assign stall_front = data_hazard;
    assign bubble_ex   = data_hazard & ~stall_all;

    assign taken = id_valid & ((id_bez & id_rD_zero) | (id_bnez & ~id_rD_zero))
                 & ~data_hazard & ~stall_all;
    assign pc_sel_branch = taken;
    assign flush_if      = taken;

    always_comb begin
        sb_ex_d = '0;
        if (id_valid && !bubble_ex) begin
            sb_ex_d.valid = 1'b1;
            sb_ex_d.wr    = (id_wrEn | id_load) && (id_rD != 5'd0);
            sb_ex_d.rd    = id_rD;
            sb_ex_d.mem   = id_memEn;
            sb_ex_d.we    = id_store;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_ex_q  <= '0;
            sb_mem_q <= '0;
            sb_wb_q  <= '0;
        end else if (!stall_all) begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_ex_q;
            sb_wb_q  <= sb_mem_q;
        end
    end

    // The retiring entry's memory fields have no consumer past MEM.
    assign wb_unused = sb_wb_q.mem ^ sb_wb_q.we;

    mem_hs_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_hs_fsm (
        .clk         (clk),
        .reset       (reset),
        .mem_op_i    (sb_mem_q.valid & sb_mem_q.mem),
        .mem_we_i    (sb_mem_q.we),
        .dmem_ack_i  (dmem_ack),
        .dmem_req_o  (dmem_req),
        .dmem_we_o   (dmem_we),
        .stall_all_o (stall_all),
        .mem_err_o   (mem_err)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_front || stall_all) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl
//               (MEM_TIMEOUT = 4, WB write-through enabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid, id_wrEn, id_memEn, id_memwrEn;
    logic        id_bez, id_bnez, id_R_type, id_rD_zero;
    logic [4:0]  id_rD, id_rA, id_rB;
    logic        dmem_ack;
    logic        stall_front, bubble_ex, stall_all, flush_if, pc_sel_branch;
    logic        dmem_req, dmem_we, mem_err;
    logic [15:0] stall_cnt;

    int errors;
    int checks;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT      (4),
        .WB_WRITE_THROUGH (1'b1),
        .STALL_CNT_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_wrEn       (id_wrEn),
        .id_memEn      (id_memEn),
        .id_memwrEn    (id_memwrEn),
        .id_bez        (id_bez),
        .id_bnez       (id_bnez),
        .id_R_type     (id_R_type),
        .id_rD         (id_rD),
        .id_rA         (id_rA),
        .id_rB         (id_rB),
        .id_rD_zero    (id_rD_zero),
        .dmem_ack      (dmem_ack),
        .stall_front   (stall_front),
        .bubble_ex     (bubble_ex),
        .stall_all     (stall_all),
        .flush_if      (flush_if),
        .pc_sel_branch (pc_sel_branch),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_none();
        id_valid = 0; id_wrEn = 0; id_memEn = 0; id_memwrEn = 0;
        id_bez = 0; id_bnez = 0; id_R_type = 0; id_rD_zero = 0;
        id_rD = 0; id_rA = 0; id_rB = 0;
    endtask

    task automatic id_rtype(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
        id_none();
        id_valid = 1; id_wrEn = 1; id_R_type = 1;
        id_rD = rd; id_rA = ra; id_rB = rb;
    endtask

    task automatic id_mem(input logic st, input logic [4:0] rd, input logic [4:0] ra);
        id_none();
        id_valid = 1; id_memEn = 1; id_memwrEn = st;
        id_rD = rd; id_rA = ra;
    endtask

    task automatic id_br(input logic bez, input logic bnez, input logic [4:0] rd, input logic zero);
        id_none();
        id_valid = 1; id_bez = bez; id_bnez = bnez; id_rD = rd; id_rD_zero = zero;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1;
        dmem_ack = 0;
        id_none();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall_front", stall_front, 0);
        chk("rst_bubble_ex", bubble_ex, 0);
        chk("rst_stall_all", stall_all, 0);
        chk("rst_flush_if", flush_if, 0);
        chk("rst_pc_sel", pc_sel_branch, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        reset = 0;

        // RAW hazard on r3: stalls while the writer is in EX and MEM
        step(); id_rtype(5'd3, 5'd1, 5'd2); #1;
        chk("raw_writer_sf", stall_front, 0);
        step(); id_rtype(5'd5, 5'd3, 5'd4); #1;
        chk("raw_ex_sf", stall_front, 1);
        chk("raw_ex_bex", bubble_ex, 1);
        step(); #1;
        chk("raw_mem_sf", stall_front, 1);
        chk("raw_mem_bex", bubble_ex, 1);
        step(); #1;
        chk("raw_wb_sf", stall_front, 0);
        chk("raw_wb_bex", bubble_ex, 0);
        chk("raw_stall_cnt", stall_cnt, 2);

        // r0 is never a hazard
        step(); id_rtype(5'd0, 5'd1, 5'd2); #1;
        chk("r0_writer_sf", stall_front, 0);
        step(); id_rtype(5'd6, 5'd0, 5'd0); #1;
        chk("r0_reader_sf", stall_front, 0);
        chk("r0_reader_bex", bubble_ex, 0);
        step(); id_none();
        repeat (3) step();

        // Branches
        id_br(1, 0, 5'd7, 1); #1;
        chk("bez_taken_pc", pc_sel_branch, 1);
        chk("bez_taken_flush", flush_if, 1);
        step(); id_none(); #1;
        chk("bez_after_pc", pc_sel_branch, 0);
        chk("bez_after_flush", flush_if, 0);
        step(); id_br(0, 1, 5'd7, 1); #1;
        chk("bnez_nt_pc", pc_sel_branch, 0);
        chk("bnez_nt_flush", flush_if, 0);
        step(); id_br(0, 1, 5'd7, 0); #1;
        chk("bnez_taken_pc", pc_sel_branch, 1);
        step(); id_rtype(5'd7, 5'd1, 5'd2); #1;
        step(); id_br(1, 0, 5'd7, 1); #1;
        chk("br_haz_pc", pc_sel_branch, 0);
        chk("br_haz_flush", flush_if, 0);
        chk("br_haz_sf", stall_front, 1);
        step(); id_none();
        repeat (3) step();

        // Load with ack three cycles after the request
        id_mem(0, 5'd9, 5'd1); #1;
        chk("ld_issue_sf", stall_front, 0);
        step(); id_none();
        step(); id_rtype(5'd10, 5'd9, 5'd0); #1;
        chk("ld_req0", dmem_req, 1);
        chk("ld_we0", dmem_we, 0);
        chk("ld_sall0", stall_all, 1);
        chk("ld_bex_forced", bubble_ex, 0);
        step(); #1;
        chk("ld_req1", dmem_req, 1);
        chk("ld_sall1", stall_all, 1);
        step(); #1;
        chk("ld_sall2", stall_all, 1);
        step(); dmem_ack = 1; #1;
        chk("ld_ack_sall", stall_all, 0);
        chk("ld_ack_req", dmem_req, 1);
        chk("ld_ack_sf", stall_front, 1);
        chk("ld_ack_bex", bubble_ex, 1);
        step(); dmem_ack = 0; #1;
        chk("ld_adv_req", dmem_req, 0);
        chk("ld_adv_sf", stall_front, 0);
        chk("ld_stall_cnt", stall_cnt, 7);
        step(); id_none();
        repeat (3) step();

        // Store acknowledged in the same cycle
        id_mem(1, 5'd11, 5'd12); #1;
        chk("st_issue_sf", stall_front, 0);
        step(); id_none();
        step(); dmem_ack = 1; #1;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_sall", stall_all, 0);
        step(); dmem_ack = 0; #1;
        chk("st_after_req", dmem_req, 0);
        chk("st_after_we", dmem_we, 0);
        chk("st_stall_cnt", stall_cnt, 7);

        // Timeout: 4 WAIT cycles without ack, then sticky error
        step(); id_mem(0, 5'd13, 5'd1);
        step(); id_none();
        step(); #1;
        chk("to_req_idle", dmem_req, 1);
        chk("to_sall_idle", stall_all, 1);
        repeat (4) step();
        #1;
        chk("to_req_last_wait", dmem_req, 1);
        chk("to_err_last_wait", mem_err, 0);
        step(); #1;
        chk("to_err_req", dmem_req, 0);
        chk("to_err_flag", mem_err, 1);
        chk("to_err_sall", stall_all, 1);
        step(); dmem_ack = 1; #1;
        chk("to_err_sticky", mem_err, 1);
        chk("to_err_sall_ack", stall_all, 1);
        chk("to_stall_cnt", stall_cnt, 13);
        reset = 1; #1;
        chk("to_rst_req", dmem_req, 0);
        chk("to_rst_sall", stall_all, 0);
        chk("to_rst_err", mem_err, 0);
        chk("to_rst_cnt", stall_cnt, 0);
        dmem_ack = 0;

        // Asynchronous reset in the middle of WAIT
        step(); reset = 0; id_mem(0, 5'd14, 5'd1);
        step(); id_none();
        step(); #1;
        chk("mw_req_idle", dmem_req, 1);
        step(); #1;
        chk("mw_req_wait", dmem_req, 1);
        #2; reset = 1; #1;
        chk("mw_rst_req", dmem_req, 0);
        chk("mw_rst_sall", stall_all, 0);
        chk("mw_rst_err", mem_err, 0);
        step(); reset = 0; #1;
        chk("mw_post_req", dmem_req, 0);
        chk("mw_post_sall", stall_all, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
